bcd2bin_time: RTL and testbench
===============================

BCD2BIN_TIME -- requirements
Module: bcd2bin_time

Interface
REQ-001 SHALL have parameter HOUR_MAX, default 23: largest legal hour value.
REQ-002 SHALL have parameter MINSEC_MAX, default 59: largest legal minute and second value.
REQ-003 SHALL have port clock  input  1: single system clock; all logic updates on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-low reset.
REQ-005 SHALL have port start  input  1: one-cycle request to convert bcd_in.
REQ-006 SHALL have port bcd_in  input  24: six BCD digits; [23:20] hour tens, [19:16] hour units, [15:12] minute tens, [11:8] minute units, [7:4] second tens, [3:0] second units.
REQ-007 SHALL have port busy  output  1: high while a request is in progress.
REQ-008 SHALL have port done  output  1: one-cycle completion pulse.
REQ-009 SHALL have port error  output  1: validity flag for the most recent request; valid while done is high and held until the next accepted start.
REQ-010 SHALL have port time_data  output  18: binary time; hour [17:12], minute [11:6], second [5:0].

Function
REQ-011 SHALL use states IDLE, CONV and DONE; busy = (state != IDLE).
REQ-012 SHALL accept start only in IDLE. start in CONV or DONE is ignored and does not queue.
REQ-013 On acceptance at edge k, SHALL capture bcd_in and validate it in the same cycle.
- Invalid if any digit > 9, hour > HOUR_MAX, minute > MINSEC_MAX or second > MINSEC_MAX.
REQ-014 Valid input: SHALL enter CONV and run 7 iterations of reverse double-dabble on all three fields in parallel.
- Iteration order: shift {bcd field, partial binary} right by 1, then subtract 3 from every BCD nibble >= 8.
- Iterations occur on edges k+1 .. k+7.
REQ-015 Valid input: SHALL enter DONE at edge k+7, then:
- done = 1 for exactly one cycle, after edge k+8;
- time_data updated at the same edge;
- error = 0.
REQ-016 Invalid input: SHALL go directly from IDLE to DONE, then:
- done = 1 and error = 1 after edge k+1;
- time_data keeps its previous value.
REQ-017 SHALL return from DONE to IDLE on the next edge. A start asserted during DONE is ignored; the earliest new acceptance is the cycle after done.
REQ-018 Binary field width SHALL be 7 bits internally and truncated to 6 bits on output; legal values never exceed 6 bits.
REQ-019 time_data SHALL change only on a successful done.

Reset
REQ-020 reset == 0 at a rising edge SHALL force the following, regardless of state, including mid-conversion:
- state = IDLE;
- busy = 0, done = 0, error = 0;
- time_data = 0;
- iteration counter cleared.
REQ-021 A conversion interrupted by reset SHALL produce no done pulse. start coincident with reset == 0 SHALL be ignored.

Structure
REQ-022 A shared package SHALL hold:
- field width constants (BCD 8, binary 6, internal binary 7, iteration count 7);
- HOUR_MAX and MINSEC_MAX defaults;
- the state encoding.
REQ-023 SHALL instantiate three copies of sub-module bcd2bin_field, each implementing one 2-digit reverse double-dabble iteration register with load, step and range check.
REQ-024 The iteration counter SHALL be 3 bits and live in the top level.

Verification
REQ-025 start with bcd_in=0x235959 at edge k -> busy 1 from k+1; done=1 and error=0 after k+8; time_data={6'd23,6'd59,6'd59}.
REQ-026 bcd_in=0x000000 -> time_data=0 and error=0 after k+8; then bcd_in=0x120530 -> time_data={6'd12,6'd5,6'd30}.
REQ-027 Out-of-range and bad-digit inputs:
- 0x240000 -> done=1, error=1 after k+1, time_data unchanged.
- 0x12A000 -> same response.
- 0x126000 -> same response.
REQ-028 start pulsed at k+3 and again at the done cycle of a running conversion -> exactly one done pulse; result matches the first bcd_in.
REQ-029 reset=0 at k+4 of a conversion -> after that edge busy=0, done=0, time_data=0; no done pulse follows; the next start converts normally.
REQ-030 Back-to-back requests, each start issued the cycle after done -> each request accepted, each with an 8-cycle latency.

Source files
------------

// File: rtl/bcd2bin_time_pkg.sv
// Shared constants and state encoding for the BCD-to-binary time converter.
package bcd2bin_time_pkg;

  // Field widths: two BCD digits in, 7-bit binary accumulated, 6 bits presented.
  localparam int BCD_W      = 8;
  localparam int BIN_W      = 6;
  localparam int BIN_INT_W  = 7;
  // Seven shifts move every bit of a 2-digit value (max 99 < 128) into the binary side.
  localparam int ITER_COUNT = 7;

  localparam int HOUR_MAX_DEF   = 23;
  localparam int MINSEC_MAX_DEF = 59;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd2bin_field.sv
// One 2-digit reverse double-dabble register: load, iterate, and range-check input.
module bcd2bin_field
  import bcd2bin_time_pkg::*;
#(
  parameter int FIELD_MAX = MINSEC_MAX_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic [BCD_W-1:0]     bcd_in,
  output logic [BIN_W-1:0]     bin_out,
  output logic                 invalid
);

  localparam int SR_W = BCD_W + BIN_INT_W;
  localparam logic [7:0] MAX_V = 8'(FIELD_MAX);

  // {bcd digits, partial binary}; bits shift from the BCD side into the binary side.
  logic [SR_W-1:0] sr_reg;
  logic [SR_W-1:0] shifted;
  logic [SR_W-1:0] stepped;

  logic [3:0] tens;
  logic [3:0] units;
  logic [7:0] value;

  assign shifted = sr_reg >> 1;
  assign stepped[BIN_INT_W-1:0] = shifted[BIN_INT_W-1:0];

  // After each shift, any BCD nibble that picked up a weight-8 bit is corrected by -3.
  genvar gi;
  generate
    for (gi = 0; gi < BCD_W / 4; gi++) begin : g_nibble
      assign stepped[BIN_INT_W + 4*gi +: 4] =
        (shifted[BIN_INT_W + 4*gi +: 4] >= 4'd8) ? (shifted[BIN_INT_W + 4*gi +: 4] - 4'd3)
                                                 : shifted[BIN_INT_W + 4*gi +: 4];
    end
  endgenerate

  // Validation looks at the live input so it is ready in the accepting cycle.
  assign tens    = bcd_in[7:4];
  assign units   = bcd_in[3:0];
  assign value   = ({4'b0, tens} * 8'd10) + {4'b0, units};
  assign invalid = (tens > 4'd9) | (units > 4'd9) | (value > MAX_V);

  // Legal results fit in 6 bits, so the top internal bit is dropped here.
  assign bin_out = sr_reg[BIN_W-1:0];

  // Shift register: load captures the digits, step performs one iteration.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sr_reg <= '0;
    end else if (load) begin
      sr_reg <= {bcd_in, {BIN_INT_W{1'b0}}};
    end else if (step) begin
      sr_reg <= stepped;
    end
  end

endmodule

// File: rtl/bcd2bin_time.sv
// Converts a 6-digit BCD hh:mm:ss value to packed binary fields with validity check.
module bcd2bin_time
  import bcd2bin_time_pkg::*;
#(
  parameter int HOUR_MAX   = HOUR_MAX_DEF,
  parameter int MINSEC_MAX = MINSEC_MAX_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3*BCD_W-1:0]   bcd_in,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [3*BIN_W-1:0]   time_data
);

  localparam logic [2:0] LAST_ITER = 3'(ITER_COUNT - 1);

  state_t state_reg, state_next;
  logic [2:0]         iter_reg, iter_next;
  logic               done_reg, done_next;
  logic               error_reg, error_next;
  logic [3*BIN_W-1:0] time_reg, time_next;

  logic               load;
  logic               step;
  logic [2:0]         invalid_vec;
  logic               invalid_any;
  logic [3*BIN_W-1:0] bin_all;

  // Field 0 = seconds, 1 = minutes, 2 = hours; lanes line up with time_data.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_field
      bcd2bin_field #(
        .FIELD_MAX ((gi == 2) ? HOUR_MAX : MINSEC_MAX)
      ) u_field (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .step    (step),
        .bcd_in  (bcd_in[gi*BCD_W +: BCD_W]),
        .bin_out (bin_all[gi*BIN_W +: BIN_W]),
        .invalid (invalid_vec[gi])
      );
    end
  endgenerate

  assign invalid_any = |invalid_vec;

  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign error     = error_reg;
  assign time_data = time_reg;

  // Next-state and datapath control; DONE publishes the result one edge later.
  always_comb begin
    state_next = state_reg;
    iter_next  = iter_reg;
    done_next  = 1'b0;
    error_next = error_reg;
    time_next  = time_reg;
    load       = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          error_next = invalid_any;
          if (invalid_any) begin
            state_next = DONE;
          end else begin
            state_next = CONV;
            load       = 1'b1;
            iter_next  = '0;
          end
        end
      end
      CONV: begin
        step = 1'b1;
        if (iter_reg == LAST_ITER) begin
          state_next = DONE;
          iter_next  = '0;
        end else begin
          iter_next = iter_reg + 3'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
        done_next  = 1'b1;
        // A rejected request leaves the previous result in place.
        if (!error_reg) begin
          time_next = bin_all;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over any request in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg <= IDLE;
      iter_reg  <= '0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
      time_reg  <= '0;
    end else begin
      state_reg <= state_next;
      iter_reg  <= iter_next;
      done_reg  <= done_next;
      error_reg <= error_next;
      time_reg  <= time_next;
    end
  end

endmodule

// File: tb/tb_bcd2bin_time.sv
// Directed bench for bcd2bin_time: latency, results, rejection, ignored starts, reset.
module tb_bcd2bin_time;

  logic        clock;
  logic        reset;
  logic        start;
  logic [23:0] bcd_in;
  logic        busy;
  logic        done;
  logic        error;
  logic [17:0] time_data;

  int checks;
  int failures;

  bcd2bin_time dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .bcd_in    (bcd_in),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .time_data (time_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issue one request; lat = edges from acceptance to the edge raising done (-1 if none).
  task automatic run_request(input logic [23:0] b, output int lat, output logic busy_k);
    int n;
    @(negedge clock);
    bcd_in = b;
    start  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start  = 1'b0;
    busy_k = busy;
    lat    = -1;
    n      = 0;
    while (lat < 0 && n < 20) begin
      @(negedge clock);
      n++;
      if (done) lat = n;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    bcd_in = 24'h0;
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", error); end
    checks++; if (time_data !== 18'h0) begin failures++; $display("FAIL reset_time got=%h exp=0", time_data); end
    reset = 1'b1;
    @(negedge clock);
    $display("txn reset: busy=%b done=%b error=%b time=%h", busy, done, error, time_data);
  endtask

  task automatic test_valid_max();
    int lat; logic bk;
    run_request(24'h235959, lat, bk);
    $display("txn 235959: lat=%0d error=%b time=%h", lat, error, time_data);
    checks++; if (bk !== 1'b1) begin failures++; $display("FAIL max_busy got=%b exp=1", bk); end
    checks++; if (lat != 8) begin failures++; $display("FAIL max_latency got=%0d exp=8", lat); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL max_error got=%b exp=0", error); end
    checks++; if (time_data !== {6'd23, 6'd59, 6'd59}) begin failures++; $display("FAIL max_time got=%h exp=%h", time_data, {6'd23, 6'd59, 6'd59}); end
    @(negedge clock);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL max_done_width got=%b exp=0", done); end
  endtask

  task automatic test_zero_and_mixed();
    int lat; logic bk;
    run_request(24'h000000, lat, bk);
    $display("txn 000000: lat=%0d error=%b time=%h", lat, error, time_data);
    checks++; if (lat != 8) begin failures++; $display("FAIL zero_latency got=%0d exp=8", lat); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL zero_error got=%b exp=0", error); end
    checks++; if (time_data !== 18'h0) begin failures++; $display("FAIL zero_time got=%h exp=0", time_data); end
    run_request(24'h120530, lat, bk);
    $display("txn 120530: lat=%0d error=%b time=%h", lat, error, time_data);
    checks++; if (lat != 8) begin failures++; $display("FAIL mixed_latency got=%0d exp=8", lat); end
    checks++; if (time_data !== {6'd12, 6'd5, 6'd30}) begin failures++; $display("FAIL mixed_time got=%h exp=%h", time_data, {6'd12, 6'd5, 6'd30}); end
  endtask

  task automatic test_invalid();
    logic [23:0] vec [3];
    int lat; logic bk;
    vec[0] = 24'h240000;
    vec[1] = 24'h12A000;
    vec[2] = 24'h126000;
    for (int i = 0; i < 3; i++) begin
      run_request(vec[i], lat, bk);
      $display("txn %h: lat=%0d error=%b time=%h", vec[i], lat, error, time_data);
      checks++; if (lat != 1) begin failures++; $display("FAIL invalid_latency[%0d] got=%0d exp=1", i, lat); end
      checks++; if (error !== 1'b1) begin failures++; $display("FAIL invalid_error[%0d] got=%b exp=1", i, error); end
      checks++; if (time_data !== {6'd12, 6'd5, 6'd30}) begin failures++; $display("FAIL invalid_time[%0d] got=%h exp=%h", i, time_data, {6'd12, 6'd5, 6'd30}); end
    end
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL invalid_idle got=%b exp=0", busy); end
  endtask

  task automatic test_ignored_start();
    int pulses; int first_n;
    @(negedge clock);
    bcd_in = 24'h010203;
    start  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start  = 1'b0;
    bcd_in = 24'h222222;
    pulses = 0;
    first_n = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      if (done) begin
        pulses++;
        if (first_n < 0) first_n = n;
      end
      // Sampled at edges 3 (CONV) and 8 (DONE state), both must be ignored.
      start = (n == 2 || n == 7);
    end
    start = 1'b0;
    $display("txn ignore: pulses=%0d first=%0d error=%b time=%h", pulses, first_n, error, time_data);
    checks++; if (pulses != 1) begin failures++; $display("FAIL ignore_pulses got=%0d exp=1", pulses); end
    checks++; if (first_n != 8) begin failures++; $display("FAIL ignore_latency got=%0d exp=8", first_n); end
    checks++; if (time_data !== {6'd1, 6'd2, 6'd3}) begin failures++; $display("FAIL ignore_time got=%h exp=%h", time_data, {6'd1, 6'd2, 6'd3}); end
  endtask

  task automatic test_reset_mid();
    int pulses; int lat; logic bk;
    @(negedge clock);
    bcd_in = 24'h235959;
    start  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    $display("txn reset_mid: busy=%b done=%b time=%h", busy, done, time_data);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done); end
    checks++; if (time_data !== 18'h0) begin failures++; $display("FAIL rstmid_time got=%h exp=0", time_data); end
    // start coincident with reset must be ignored
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    reset = 1'b1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_start_busy got=%b exp=0", busy); end
    pulses = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clock);
      if (done) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL rstmid_pulse got=%0d exp=0", pulses); end
    run_request(24'h081530, lat, bk);
    $display("txn 081530: lat=%0d error=%b time=%h", lat, error, time_data);
    checks++; if (lat != 8) begin failures++; $display("FAIL rstmid_next_latency got=%0d exp=8", lat); end
    checks++; if (time_data !== {6'd8, 6'd15, 6'd30}) begin failures++; $display("FAIL rstmid_next_time got=%h exp=%h", time_data, {6'd8, 6'd15, 6'd30}); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] vec [3];
    logic [17:0] exp [3];
    int lat; logic bk;
    vec[0] = 24'h010101; exp[0] = {6'd1, 6'd1, 6'd1};
    vec[1] = 24'h195907; exp[1] = {6'd19, 6'd59, 6'd7};
    vec[2] = 24'h230000; exp[2] = {6'd23, 6'd0, 6'd0};
    for (int i = 0; i < 3; i++) begin
      run_request(vec[i], lat, bk);
      $display("txn b2b %h: lat=%0d busy_k=%b time=%h", vec[i], lat, bk, time_data);
      checks++; if (bk !== 1'b1) begin failures++; $display("FAIL b2b_accept[%0d] got=%b exp=1", i, bk); end
      checks++; if (lat != 8) begin failures++; $display("FAIL b2b_latency[%0d] got=%0d exp=8", i, lat); end
      checks++; if (time_data !== exp[i]) begin failures++; $display("FAIL b2b_time[%0d] got=%h exp=%h", i, time_data, exp[i]); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    start    = 1'b0;
    bcd_in   = 24'h0;
    test_reset();
    test_valid_max();
    test_zero_and_mixed();
    test_invalid();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
